// File: rtl/core_seq.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB,
// owning the instruction register, the fetch/data handshakes and the retire counter.
module core_seq #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        if_req,
    input  logic        if_ack,
    input  logic [31:0] if_rdata,
    output logic [31:0] inst,
    input  logic        mem_acs,
    input  logic        rd_w_ena,
    input  logic        sys_inst,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic        pc_we,
    output logic        rf_we,
    output logic [63:0] instret,
    output logic        halt,
    output logic        err,
    output logic [2:0]  state
);

    // Handshakes: a request (if_req / mem_req) is held high in every cycle of its
    // state and completes on the rising edge where the matching ack is sampled high;
    // acks seen in any other state are ignored.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0]      NOP       = 32'h0000_0013;

    state_t           cur_state;
    state_t           nxt_state;
    logic [CNT_W-1:0] wcnt;
    logic             wait_ack;
    logic             timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // wcnt is zero whenever we are outside FETCH/MEM, so it starts at 0 on entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt <= '0;
        end else if ((cur_state == S_FETCH || cur_state == S_MEM) && !wait_ack) begin
            wcnt <= wcnt + 1'b1;
        end else begin
            wcnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst <= NOP;
        end else if (cur_state == S_FETCH && if_ack) begin
            inst <= if_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instret <= '0;
        end else if (cur_state == S_WB) begin
            instret <= instret + 64'd1;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        if_req    = 1'b0;
        mem_req   = 1'b0;
        pc_we     = 1'b0;
        rf_we     = 1'b0;
        halt      = 1'b0;
        err       = 1'b0;
        wait_ack  = (cur_state == S_FETCH && if_ack) || (cur_state == S_MEM && mem_ack);
        // Ack wins over timeout when both land in the same cycle.
        timeout   = (TIMEOUT != 0) && !wait_ack && (wcnt == WAIT_LAST);
        case (cur_state)
            S_IDLE: begin
                if (run) nxt_state = S_FETCH;
            end
            S_FETCH: begin
                if_req = 1'b1;
                if (if_ack)       nxt_state = S_DECODE;
                else if (timeout) nxt_state = S_ERR;
            end
            S_DECODE: begin
                // System instructions never retire, even when flagged as memory ops.
                if (sys_inst) nxt_state = S_HALT;
                else          nxt_state = S_EXEC;
            end
            S_EXEC: begin
                if (mem_acs) nxt_state = S_MEM;
                else         nxt_state = S_WB;
            end
            S_MEM: begin
                mem_req = 1'b1;
                if (mem_ack)      nxt_state = S_WB;
                else if (timeout) nxt_state = S_ERR;
            end
            S_WB: begin
                pc_we     = 1'b1;
                rf_we     = rd_w_ena;
                nxt_state = S_FETCH;
            end
            S_HALT: begin
                halt = 1'b1;
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase
    end

    assign state = cur_state;

endmodule

// File: tb/tb_core_seq.sv
// Self-checking bench for core_seq: directed scenario tasks plus a retire scoreboard
// that matches every WB strobe against the instruction and rf_we expected for it.
module tb_core_seq;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ADDI   = 32'h0010_0093;
    localparam logic [31:0] LW     = 32'h0000_a103;
    localparam logic [31:0] SW     = 32'h0020_a023;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        if_req;
    logic        if_ack = 1'b0;
    logic [31:0] if_rdata = '0;
    logic [31:0] inst;
    logic        mem_acs = 1'b0;
    logic        rd_w_ena = 1'b0;
    logic        sys_inst = 1'b0;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic        pc_we;
    logic        rf_we;
    logic [63:0] instret;
    logic        halt;
    logic        err;
    logic [2:0]  state;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_ret;
    logic [32:0] exp_q[$];

    core_seq #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .run(run),
        .if_req(if_req), .if_ack(if_ack), .if_rdata(if_rdata), .inst(inst),
        .mem_acs(mem_acs), .rd_w_ena(rd_w_ena), .sys_inst(sys_inst),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_we(pc_we), .rf_we(rf_we), .instret(instret),
        .halt(halt), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    // Retire scoreboard: each WB cycle must match the oldest expected {rf_we, inst}.
    always @(negedge clk) begin
        if (!rst && pc_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL retire_unexpected: WB with inst=%h, none expected", inst);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({rf_we, inst} !== e) begin
                    errors++;
                    $display("FAIL retire: got rf_we=%b inst=%h, want rf_we=%b inst=%h",
                             rf_we, inst, e[32], e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_fetch();
        rst = 1'b1; run = 1'b0; if_ack = 1'b0; mem_ack = 1'b0;
        sys_inst = 1'b0; mem_acs = 1'b0; rd_w_ena = 1'b0;
        tick();
        rst = 1'b0; run = 1'b1;
        tick();
        run = 1'b0;
        exp_ret = 64'd0;
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL go_fetch_state: got %0d, want 1", state);
        end
    endtask

    // Runs one instruction from FETCH back to FETCH; mcyc is the MEM cycle holding the ack.
    task automatic run_inst(input logic [31:0] w, input logic m, input logic rdw, input int mcyc);
        int cyc;
        int mreq;
        bit done;
        cyc = 0; mreq = 0; done = 0;
        mem_acs = m; rd_w_ena = rdw; sys_inst = 1'b0; if_rdata = w;
        exp_q.push_back({rdw, w});
        exp_ret = exp_ret + 64'd1;
        while (!done && cyc < 20) begin
            if (mem_req) mreq++;
            mem_ack = mem_req && (mreq == mcyc);
            if_ack  = (cyc == 0);
            tick();
            cyc++;
            if (state == 3'd1) done = 1;
        end
        if_ack = 1'b0; mem_ack = 1'b0;
        checks++;
        if (!done || cyc != (m ? 4 + mcyc : 4)) begin
            errors++;
            $display("FAIL inst_cycles: got %0d (done=%0d), want %0d", cyc, done, m ? 4 + mcyc : 4);
        end
        checks++;
        if (mreq != (m ? mcyc : 0)) begin
            errors++;
            $display("FAIL mem_req_cycles: got %0d, want %0d", mreq, m ? mcyc : 0);
        end
        checks++;
        if (instret !== exp_ret) begin
            errors++;
            $display("FAIL instret: got %0d, want %0d", instret, exp_ret);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({state, if_req, mem_req, pc_we, rf_we, halt, err} !== 9'd0) begin
                errors++;
                $display("FAIL reset_outputs: got st=%0d ifr=%b mr=%b pc=%b rf=%b h=%b e=%b, want all 0",
                         state, if_req, mem_req, pc_we, rf_we, halt, err);
            end
            checks++;
            if (inst !== NOP || instret !== 64'd0) begin
                errors++;
                $display("FAIL reset_regs: got inst=%h instret=%0d, want %h 0", inst, instret, NOP);
            end
        end
    endtask

    task automatic test_run();
        logic [2:0] seq[4];
        seq = '{3'd1, 3'd2, 3'd3, 3'd5};
        run = 1'b1; if_ack = 1'b1; if_rdata = ADDI;
        rd_w_ena = 1'b1; mem_acs = 1'b0; sys_inst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i % 4 == 0) exp_q.push_back({1'b1, ADDI});
            checks++;
            if (state !== seq[i % 4] || pc_we !== (i % 4 == 3) || rf_we !== (i % 4 == 3)) begin
                errors++;
                $display("FAIL run_seq[%0d]: got st=%0d pc=%b rf=%b, want st=%0d strobe=%b",
                         i, state, pc_we, rf_we, seq[i % 4], i % 4 == 3);
            end
        end
        tick();
        checks++;
        if (state !== 3'd1 || instret !== 64'd3) begin
            errors++;
            $display("FAIL run_instret3: got st=%0d instret=%0d, want 1 3", state, instret);
        end
        // Dropping run must not stop the core once it has left IDLE.
        run = 1'b0;
        exp_q.push_back({1'b1, ADDI});
        repeat (4) tick();
        if_ack = 1'b0;
        checks++;
        if (state !== 3'd1 || instret !== 64'd4) begin
            errors++;
            $display("FAIL run_ignored: got st=%0d instret=%0d, want 1 4", state, instret);
        end
    endtask

    task automatic test_load();
        go_fetch();
        run_inst(LW, 1'b1, 1'b1, 3);
    endtask

    task automatic test_store();
        go_fetch();
        run_inst(SW, 1'b1, 1'b0, 1);
    endtask

    task automatic test_back_to_back();
        go_fetch();
        for (int k = 0; k < 6; k++) begin
            int kind;
            kind = $urandom_range(0, 2);
            run_inst($urandom, kind != 0, kind != 2, $urandom_range(1, 3));
        end
    endtask

    task automatic test_ebreak();
        go_fetch();
        sys_inst = 1'b1; mem_acs = 1'b1; if_ack = 1'b1; if_rdata = EBREAK;
        tick();
        if_ack = 1'b0;
        tick();
        checks++;
        if (state !== 3'd6 || halt !== 1'b1 || pc_we !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL ebreak_halt: got st=%0d halt=%b pc=%b mr=%b, want 6 1 0 0", state, halt, pc_we, mem_req);
        end
        if_ack = 1'b1; if_rdata = ADDI;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (state !== 3'd6 || instret !== 64'd0 || inst !== EBREAK || if_req !== 1'b0) begin
                errors++;
                $display("FAIL halt_absorb: got st=%0d instret=%0d inst=%h ifr=%b, want 6 0 %h 0",
                         state, instret, inst, if_req, EBREAK);
            end
        end
        rst = 1'b1; if_ack = 1'b0; sys_inst = 1'b0; mem_acs = 1'b0;
        tick();
        rst = 1'b0;
        checks++;
        if (state !== 3'd0 || halt !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset: got st=%0d halt=%b, want 0 0", state, halt);
        end
    endtask

    task automatic test_timeout();
        go_fetch();
        repeat (3) tick();
        checks++;
        if (state !== 3'd1 || if_req !== 1'b1) begin
            errors++;
            $display("FAIL fetch_wait4: got st=%0d ifr=%b, want 1 1", state, if_req);
        end
        tick();
        checks++;
        if (state !== 3'd7 || err !== 1'b1 || if_req !== 1'b0) begin
            errors++;
            $display("FAIL fetch_timeout: got st=%0d err=%b ifr=%b, want 7 1 0", state, err, if_req);
        end
        if_ack = 1'b1;
        repeat (2) tick();
        if_ack = 1'b0;
        checks++;
        if (state !== 3'd7 || err !== 1'b1) begin
            errors++;
            $display("FAIL err_absorb: got st=%0d err=%b, want 7 1", state, err);
        end
        // Ack arriving in the last allowed cycle wins over the timeout.
        go_fetch();
        if_rdata = ADDI;
        repeat (3) tick();
        if_ack = 1'b1;
        tick();
        if_ack = 1'b0;
        checks++;
        if (state !== 3'd2 || err !== 1'b0 || inst !== ADDI) begin
            errors++;
            $display("FAIL fetch_ack_last: got st=%0d err=%b inst=%h, want 2 0 %h", state, err, inst, ADDI);
        end
    endtask

    task automatic test_mem_timeout();
        go_fetch();
        mem_acs = 1'b1; rd_w_ena = 1'b1; if_ack = 1'b1; if_rdata = LW;
        tick();
        if_ack = 1'b0;
        repeat (5) tick();
        checks++;
        if (state !== 3'd4 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL mem_wait4: got st=%0d mr=%b, want 4 1", state, mem_req);
        end
        tick();
        checks++;
        if (state !== 3'd7 || err !== 1'b1 || mem_req !== 1'b0 || instret !== 64'd0) begin
            errors++;
            $display("FAIL mem_timeout: got st=%0d err=%b mr=%b instret=%0d, want 7 1 0 0",
                     state, err, mem_req, instret);
        end
    endtask

    task automatic test_reset_mid_mem();
        go_fetch();
        run_inst(ADDI, 1'b0, 1'b1, 1);
        mem_acs = 1'b1; if_ack = 1'b1; if_rdata = LW;
        tick();
        if_ack = 1'b0;
        tick();
        tick();
        checks++;
        if (state !== 3'd4 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_mem_setup: got st=%0d mr=%b, want 4 1", state, mem_req);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; mem_acs = 1'b0;
        checks++;
        if (state !== 3'd0 || mem_req !== 1'b0 || instret !== 64'd0 || inst !== NOP) begin
            errors++;
            $display("FAIL mid_mem_reset: got st=%0d mr=%b instret=%0d inst=%h, want 0 0 0 %h",
                     state, mem_req, instret, inst, NOP);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_load();
        test_store();
        test_back_to_back();
        test_ebreak();
        test_timeout();
        test_mem_timeout();
        test_reset_mid_mem();
        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending retires, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
